// File: rtl/lc2k_mc_ctrl.sv
// lc2k_mc_ctrl: multicycle LC2K sequencer; fetches over a ready-handshake memory port,
// decodes, and drives the 8x32 register file through EXEC/MEM/WB steps.
module lc2k_mc_ctrl #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [2:0]        regA,
    output logic [2:0]        regB,
    input  logic [31:0]       readRegA,
    input  logic [31:0]       readRegB,
    output logic [2:0]        write_reg,
    output logic              write_enable,
    output logic [31:0]       write_val,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [31:0]       instr_count
);
    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    state_t            state, state_next;
    logic [24:0]       ir;
    logic [31:0]       a, b, result, alu, off;
    logic [2:0]        op;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_sw, retire;

    assign op     = ir[24:22];
    assign regA   = ir[21:19];
    assign regB   = ir[18:16];
    assign off    = {{16{ir[15]}}, ir[15:0]};
    assign pc_inc = pc + ADDR_W'(1);
    assign is_sw  = op == OP_SW;
    assign alu    = (op == OP_ADD)  ? a + b :
                    (op == OP_NOR)  ? ~(a | b) :
                    (op == OP_JALR) ? 32'(pc_inc) : a + off;

    // halt and noop both retire straight out of DECODE (op 11x)
    assign retire = (state == S_DECODE && op[2:1] == 2'b11) ||
                    (state == S_EXEC && op == OP_BEQ) ||
                    (state == S_MEM && is_sw && mem_ready) ||
                    (state == S_WB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RST;
        else        state <= state_next;
    end

    // outputs depend on state and registered fields only; mem_ready steers next state alone
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        write_enable = 1'b0;
        write_reg    = '0;
        write_val    = '0;
        halted       = 1'b0;
        case (state)
            S_RST:    state_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                mem_addr   = pc;
                state_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: state_next = (op == OP_HALT) ? S_HALT : (op == OP_NOOP) ? S_FETCH : S_EXEC;
            S_EXEC:   state_next = (op == OP_BEQ) ? S_FETCH : (op == OP_LW || is_sw) ? S_MEM : S_WB;
            S_MEM: begin
                mem_req    = 1'b1;
                mem_we     = is_sw;
                mem_addr   = result[ADDR_W-1:0];
                mem_wdata  = is_sw ? b : '0;
                state_next = !mem_ready ? S_MEM : is_sw ? S_FETCH : S_WB;
            end
            S_WB: begin
                write_enable = 1'b1;
                write_reg    = (op == OP_ADD || op == OP_NOR) ? ir[2:0] : ir[18:16];
                write_val    = result;
                state_next   = S_FETCH;
            end
            S_HALT:   halted = 1'b1;
            default:  state_next = S_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            result      <= '0;
            instr_count <= '0;
        end else begin
            if (retire) instr_count <= instr_count + 32'd1;
            case (state)
                S_FETCH:  if (mem_ready) ir <= mem_rdata[24:0];
                S_DECODE: begin
                    a <= readRegA;
                    b <= readRegB;
                    if (op[2:1] == 2'b11) pc <= pc_inc;
                end
                S_EXEC: begin
                    if (op == OP_BEQ) pc <= (a == b) ? pc_inc + off[ADDR_W-1:0] : pc_inc;
                    else              result <= alu;
                end
                S_MEM: begin
                    if (mem_ready && is_sw) pc <= pc_inc;
                    if (mem_ready && !is_sw) result <= mem_rdata;
                end
                // jalr jumps to the regA value captured in DECODE, before its own write
                S_WB:     pc <= (op == OP_JALR) ? a[ADDR_W-1:0] : pc_inc;
                default:  ;
            endcase
        end
    end
endmodule
